// File: rtl/exc_ctrl_pkg.sv
// Shared constants for the exception sequencer: exception codes, stall
// vectors, CP0 Status/Cause bit positions, default vectors and FSM states.
// Optional feature macro used by this slice: EXC_CTRL_BEV_EN.
package exc_ctrl_pkg;

    localparam logic [31:0] EXC_NONE    = 32'h0000_0000;
    localparam logic [31:0] EXC_INT     = 32'h0000_0001;
    localparam logic [31:0] EXC_SYSCALL = 32'h0000_0008;
    localparam logic [31:0] EXC_INVALID = 32'h0000_000a;
    localparam logic [31:0] EXC_TRAP    = 32'h0000_000d;
    localparam logic [31:0] EXC_OVF     = 32'h0000_000c;
    localparam logic [31:0] EXC_ERET    = 32'h0000_000e;

    // Stall vector order is {wb,mem,ex,id,if,pc}.
    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;

    localparam int STATUS_IE_BIT  = 0;
    localparam int STATUS_EXL_BIT = 1;
    localparam int STATUS_IM_LSB  = 8;
    localparam int STATUS_BEV_BIT = 22;
    localparam int CAUSE_IP_LSB   = 8;

    localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_0020;
    localparam logic [31:0] BEV_VECTOR_DEF = 32'hBFC0_0380;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_FLUSH = 1'b1
    } exc_state_t;

    // An interrupt is requestable when enabled, not at exception level,
    // and at least one unmasked pending line is up.
    function automatic logic int_request(input logic [31:0] status, input logic [31:0] cause);
        return status[STATUS_IE_BIT] & ~status[STATUS_EXL_BIT]
             & (|(cause[CAUSE_IP_LSB +: 8] & status[STATUS_IM_LSB +: 8]));
    endfunction

endpackage

// File: rtl/exc_ctrl_if.sv
// Bundle of MEM-stage, CP0 and pipeline-control signals around exc_ctrl.
// There is no valid/ready pair here: an exception is accepted in the single
// cycle in which excepttype_o is non-zero; inst_valid_i qualifies the MEM
// flags, and flush_o qualifies new_pc_o. dbg_state exposes the FSM state.
interface exc_ctrl_if;
    import exc_ctrl_pkg::*;

    logic [31:0] status_i;
    logic [31:0] cause_i;
    logic [31:0] epc_i;
    logic        inst_valid_i;
    logic [31:0] inst_addr_i;
    logic        in_delayslot_i;
    logic        exc_syscall_i;
    logic        exc_invalid_i;
    logic        exc_trap_i;
    logic        exc_ovf_i;
    logic        exc_eret_i;
    logic        stallreq_id_i;
    logic        stallreq_ex_i;
    logic [31:0] excepttype_o;
    logic [31:0] cur_inst_addr_o;
    logic        in_delayslot_o;
    logic        flush_o;
    logic [31:0] new_pc_o;
    logic [5:0]  stall_o;
    logic        busy_o;
    exc_state_t  dbg_state;

    modport master (
        output status_i, cause_i, epc_i, inst_valid_i, inst_addr_i, in_delayslot_i,
               exc_syscall_i, exc_invalid_i, exc_trap_i, exc_ovf_i, exc_eret_i,
               stallreq_id_i, stallreq_ex_i,
        input  excepttype_o, cur_inst_addr_o, in_delayslot_o, flush_o, new_pc_o,
               stall_o, busy_o, dbg_state
    );

    modport slave (
        input  status_i, cause_i, epc_i, inst_valid_i, inst_addr_i, in_delayslot_i,
               exc_syscall_i, exc_invalid_i, exc_trap_i, exc_ovf_i, exc_eret_i,
               stallreq_id_i, stallreq_ex_i,
        output excepttype_o, cur_inst_addr_o, in_delayslot_o, flush_o, new_pc_o,
               stall_o, busy_o, dbg_state
    );

endinterface

// File: rtl/exc_ctrl_prio_enc.sv
// Fixed-priority encoder: pending interrupt, then syscall, invalid, trap,
// overflow and eret, producing the cp0_reg excepttype code (0 = none).
module exc_ctrl_prio_enc
    import exc_ctrl_pkg::*;
(
    input  logic        i_int_pend,
    input  logic        i_syscall,
    input  logic        i_invalid,
    input  logic        i_trap,
    input  logic        i_ovf,
    input  logic        i_eret,
    output logic [31:0] o_code
);

    // Highest-priority active source selects the code.
    always_comb begin
        o_code = EXC_NONE;
        if (i_int_pend)     o_code = EXC_INT;
        else if (i_syscall) o_code = EXC_SYSCALL;
        else if (i_invalid) o_code = EXC_INVALID;
        else if (i_trap)    o_code = EXC_TRAP;
        else if (i_ovf)     o_code = EXC_OVF;
        else if (i_eret)    o_code = EXC_ERET;
    end

endmodule

// File: rtl/exc_ctrl.sv
// Exception/interrupt sequencer between MEM and cp0_reg: accepts the
// highest-priority exception, reports it to cp0_reg for one cycle, then
// holds flush_o for FLUSH_CYCLES cycles while presenting the new PC.
// Outside of exceptions it merges ID/EX stall requests into stall_o.
// Optional macro EXC_CTRL_BEV_EN: Status.BEV selects the boot vector.
module exc_ctrl
    import exc_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEF,
    parameter logic [31:0] BEV_VECTOR   = BEV_VECTOR_DEF,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    exc_ctrl_if.slave  bus
);

    exc_state_t  r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_new_pc;
    logic        r_int_pend;

    logic [31:0] w_code;
    logic        w_int_req;
    logic        w_idle;
    logic        w_accept;
    logic [31:0] w_vector;
    logic [31:0] w_target;

    assign w_int_req = int_request(bus.status_i, bus.cause_i);
    assign w_idle    = (r_state == S_IDLE);

    exc_ctrl_prio_enc u_prio (
        .i_int_pend (r_int_pend),
        .i_syscall  (bus.exc_syscall_i),
        .i_invalid  (bus.exc_invalid_i),
        .i_trap     (bus.exc_trap_i),
        .i_ovf      (bus.exc_ovf_i),
        .i_eret     (bus.exc_eret_i),
        .o_code     (w_code)
    );

    // Bubbles never accept anything, so a pending interrupt waits for a real instruction.
    assign w_accept = ~rst & w_idle & bus.inst_valid_i & (w_code != EXC_NONE);

`ifdef EXC_CTRL_BEV_EN
    assign w_vector = bus.status_i[STATUS_BEV_BIT] ? BEV_VECTOR : EXC_VECTOR;
    logic w_unused;
    assign w_unused = ^{bus.status_i, bus.cause_i};
`else
    assign w_vector = EXC_VECTOR;
    logic w_unused;
    assign w_unused = ^{bus.status_i, bus.cause_i, BEV_VECTOR};
`endif

    assign w_target = (w_code == EXC_ERET) ? bus.epc_i : w_vector;

    // Accept-cycle report to cp0_reg and stall arbitration while idle.
    always_comb begin
        bus.excepttype_o    = EXC_NONE;
        bus.cur_inst_addr_o = 32'h0;
        bus.in_delayslot_o  = 1'b0;
        bus.stall_o         = STALL_NONE;
        if (w_accept) begin
            bus.excepttype_o    = w_code;
            bus.cur_inst_addr_o = bus.inst_addr_i;
            bus.in_delayslot_o  = bus.in_delayslot_i;
        end else if (~rst && w_idle) begin
            if (bus.stallreq_ex_i)      bus.stall_o = STALL_EX;
            else if (bus.stallreq_id_i) bus.stall_o = STALL_ID;
        end
    end

    assign bus.flush_o   = (r_state == S_FLUSH);
    assign bus.new_pc_o  = (r_state == S_FLUSH) ? r_new_pc : 32'h0;
    assign bus.busy_o    = (r_state != S_IDLE);
    assign bus.dbg_state = r_state;

    // Sequencer: latch the redirect target on acceptance, count down the flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= 4'd0;
            r_new_pc <= 32'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state  <= S_FLUSH;
                        r_cnt    <= 4'(FLUSH_CYCLES - 1);
                        r_new_pc <= w_target;
                    end
                end
                S_FLUSH: begin
                    if (r_cnt == 4'd0) r_state <= S_IDLE;
                    else               r_cnt   <= r_cnt - 4'd1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Interrupt pending flag: resampled every cycle, dropped when the interrupt is taken.
    always_ff @(posedge clk) begin
        if (rst)                                  r_int_pend <= 1'b0;
        else if (w_accept && w_code == EXC_INT)   r_int_pend <= 1'b0;
        else                                      r_int_pend <= w_int_req;
    end

endmodule

// File: tb/tb_exc_ctrl.sv
// Bench for exc_ctrl: directed scenarios plus random traffic, each cycle's
// expected outputs come from a behavioural model and are queued; a monitor
// compares them against the DUT on the falling edge.
module tb_exc_ctrl;

    localparam logic [31:0] EXC_VEC      = 32'h0000_0020;
    localparam logic [31:0] BEV_VEC      = 32'hBFC0_0380;
    localparam int          FLUSH_CYCLES = 2;

    typedef struct packed {
        logic [31:0] code;
        logic [31:0] addr;
        logic        ds;
        logic        flush;
        logic [31:0] npc;
        logic [5:0]  stall;
        logic        busy;
    } exp_t;

    localparam int W = $bits(exp_t);

    logic clk;
    logic rst;
    logic [W-1:0] exp_q[$];
    int checks;
    int errors;
    int cyc;

    // Reference model state
    int          m_left;
    logic [31:0] m_target;
    logic        m_pend;

    exp_t mon_e;

    exc_ctrl_if ifc ();

    exc_ctrl #(
        .EXC_VECTOR   (EXC_VEC),
        .BEV_VECTOR   (BEV_VEC),
        .FLUSH_CYCLES (FLUSH_CYCLES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, act, expv);
        end
    endtask

    // Monitor: every cycle the DUT presents a full output set
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("excepttype", ifc.excepttype_o, mon_e.code);
            chk("cur_inst_addr", ifc.cur_inst_addr_o, mon_e.addr);
            chk("in_delayslot", {31'b0, ifc.in_delayslot_o}, {31'b0, mon_e.ds});
            chk("flush", {31'b0, ifc.flush_o}, {31'b0, mon_e.flush});
            chk("new_pc", ifc.new_pc_o, mon_e.npc);
            chk("stall", {26'b0, ifc.stall_o}, {26'b0, mon_e.stall});
            chk("busy", {31'b0, ifc.busy_o}, {31'b0, mon_e.busy});
            cyc++;
        end
    end

    // Behavioural model: outputs for the current inputs, then advance one clock
    task automatic model_step();
        exp_t        e;
        logic [31:0] code;
        logic [31:0] vec;
        logic        pend_now;
        logic        accepted;
        logic        int_taken;
        logic [W-1:0] v;
        e         = '0;
        code      = 32'h0;
        accepted  = 1'b0;
        int_taken = 1'b0;
        pend_now  = ifc.status_i[0] && !ifc.status_i[1]
                    && ((ifc.cause_i[15:8] & ifc.status_i[15:8]) != 8'h00);
`ifdef EXC_CTRL_BEV_EN
        vec = ifc.status_i[22] ? BEV_VEC : EXC_VEC;
`else
        vec = EXC_VEC;
`endif
        e.flush = (m_left > 0);
        e.busy  = (m_left > 0);
        e.npc   = (m_left > 0) ? m_target : 32'h0;
        if (!rst && m_left == 0) begin
            if (ifc.inst_valid_i) begin
                if (m_pend)                 begin code = 32'h1; int_taken = 1'b1; end
                else if (ifc.exc_syscall_i) code = 32'h8;
                else if (ifc.exc_invalid_i) code = 32'ha;
                else if (ifc.exc_trap_i)    code = 32'hd;
                else if (ifc.exc_ovf_i)     code = 32'hc;
                else if (ifc.exc_eret_i)    code = 32'he;
            end
            if (code != 32'h0) begin
                accepted = 1'b1;
                e.code   = code;
                e.addr   = ifc.inst_addr_i;
                e.ds     = ifc.in_delayslot_i;
            end else if (ifc.stallreq_ex_i) begin
                e.stall = 6'b001111;
            end else if (ifc.stallreq_id_i) begin
                e.stall = 6'b000111;
            end
        end
        v = e;
        exp_q.push_back(v);
        if (rst) begin
            m_left   = 0;
            m_pend   = 1'b0;
            m_target = 32'h0;
        end else begin
            if (accepted) begin
                m_left   = FLUSH_CYCLES;
                m_target = (code == 32'he) ? ifc.epc_i : vec;
            end else if (m_left > 0) begin
                m_left--;
            end
            m_pend = int_taken ? 1'b0 : pend_now;
        end
    endtask

    // Driver tasks
    task automatic idle_inputs();
        ifc.status_i       = 32'h0;
        ifc.cause_i        = 32'h0;
        ifc.epc_i          = 32'h0;
        ifc.inst_valid_i   = 1'b0;
        ifc.inst_addr_i    = 32'h0;
        ifc.in_delayslot_i = 1'b0;
        clear_flags();
        ifc.stallreq_id_i  = 1'b0;
        ifc.stallreq_ex_i  = 1'b0;
    endtask

    task automatic clear_flags();
        ifc.exc_syscall_i = 1'b0;
        ifc.exc_invalid_i = 1'b0;
        ifc.exc_trap_i    = 1'b0;
        ifc.exc_ovf_i     = 1'b0;
        ifc.exc_eret_i    = 1'b0;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            model_step();
            @(posedge clk);
            #1;
        end
    endtask

    // Stimulus
    initial begin
        checks   = 0;
        errors   = 0;
        cyc      = 0;
        m_left   = 0;
        m_pend   = 1'b0;
        m_target = 32'h0;
        rst      = 1'b1;
        idle_inputs();
        @(posedge clk);
        #1;
        step(2);
        rst = 1'b0;
        step(1);

        // Interrupt taken one cycle after it becomes pending
        ifc.status_i     = 32'h1000_FF01;
        ifc.cause_i      = 32'h0000_0400;
        ifc.inst_valid_i = 1'b1;
        ifc.inst_addr_i  = 32'h0000_0100;
        step(2);
        ifc.cause_i = 32'h0;
        step(3);

        // Priority: syscall beats ovf and eret
        ifc.status_i      = 32'h0;
        ifc.inst_addr_i   = 32'h0000_0200;
        ifc.in_delayslot_i = 1'b1;
        ifc.exc_syscall_i = 1'b1;
        ifc.exc_ovf_i     = 1'b1;
        ifc.exc_eret_i    = 1'b1;
        step(1);
        clear_flags();
        ifc.in_delayslot_i = 1'b0;
        step(3);

        // eret redirects to EPC
        ifc.epc_i      = 32'h0000_0480;
        ifc.exc_eret_i = 1'b1;
        step(1);
        clear_flags();
        step(3);

        // Masked interrupts: EXL set, then IE clear
        ifc.cause_i  = 32'h0000_0400;
        ifc.status_i = 32'h1000_FF03;
        step(3);
        ifc.status_i = 32'h1000_FF00;
        step(3);
        ifc.cause_i  = 32'h0;
        ifc.status_i = 32'h0;

        // Stall arbitration, then trap wins over an EX stall
        ifc.stallreq_ex_i = 1'b1;
        ifc.stallreq_id_i = 1'b1;
        step(1);
        ifc.stallreq_ex_i = 1'b0;
        step(1);
        ifc.stallreq_id_i = 1'b0;
        ifc.stallreq_ex_i = 1'b1;
        ifc.exc_trap_i    = 1'b1;
        step(1);
        clear_flags();
        ifc.stallreq_ex_i = 1'b0;
        step(3);

        // Overflow raised during the flush is ignored
        ifc.exc_syscall_i = 1'b1;
        step(1);
        ifc.exc_syscall_i = 1'b0;
        ifc.exc_ovf_i     = 1'b1;
        step(2);
        ifc.exc_ovf_i = 1'b0;
        step(1);

        // Reset during the flush
        ifc.exc_invalid_i = 1'b1;
        step(1);
        ifc.exc_invalid_i = 1'b0;
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(2);

        // BEV set with invalid instruction
        ifc.status_i      = 32'h0040_0000;
        ifc.exc_invalid_i = 1'b1;
        step(1);
        clear_flags();
        step(3);

        // Interrupt waits through bubbles
        ifc.status_i     = 32'h1000_FF01;
        ifc.cause_i      = 32'h0000_0400;
        ifc.inst_valid_i = 1'b0;
        step(3);
        ifc.inst_valid_i = 1'b1;
        step(1);
        ifc.cause_i = 32'h0;
        step(3);
        ifc.status_i = 32'h0;

        // Back-to-back syscalls
        ifc.exc_syscall_i = 1'b1;
        step(8);
        clear_flags();
        step(2);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 79) == 0);
            ifc.status_i = 32'h0;
            ifc.status_i[0]     = ($urandom_range(0, 3) != 0);
            ifc.status_i[1]     = ($urandom_range(0, 3) == 0);
            ifc.status_i[15:8]  = 8'($urandom);
            ifc.status_i[22]    = 1'($urandom_range(0, 1));
            ifc.cause_i         = ($urandom_range(0, 3) == 0) ? {16'h0, 8'($urandom), 8'h0} : 32'h0;
            ifc.epc_i           = $urandom & 32'hFFFF_FFFC;
            ifc.inst_valid_i    = ($urandom_range(0, 3) != 0);
            ifc.inst_addr_i     = $urandom & 32'hFFFF_FFFC;
            ifc.in_delayslot_i  = 1'($urandom_range(0, 1));
            ifc.exc_syscall_i   = ($urandom_range(0, 9) == 0);
            ifc.exc_invalid_i   = ($urandom_range(0, 9) == 0);
            ifc.exc_trap_i      = ($urandom_range(0, 9) == 0);
            ifc.exc_ovf_i       = ($urandom_range(0, 9) == 0);
            ifc.exc_eret_i      = ($urandom_range(0, 9) == 0);
            ifc.stallreq_id_i   = ($urandom_range(0, 2) == 0);
            ifc.stallreq_ex_i   = ($urandom_range(0, 2) == 0);
            step(1);
        end
        rst = 1'b0;
        idle_inputs();
        step(4);

        @(negedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
